// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the restoring divider: the FSM state encoding,
// aligned with the shift-add multiplier's encoding.
package shift_sub_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : shift_sub_divider_pkg

// File: rtl/shift_sub_divider_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, and shift the
// resulting quotient bit into the bottom of the quotient shift register.
module divider_step #(
  parameter int width_p = 4
) (
  input  logic [width_p:0]   rem_i,
  input  logic [width_p-1:0] quo_i,
  input  logic [width_p-1:0] div_i,
  output logic [width_p:0]   rem_o,
  output logic [width_p-1:0] quo_o
);

  logic [width_p:0] rem_shift_s;
  logic [width_p:0] div_ext_s;

  // Trial subtraction; the remainder is restored when the divisor does not fit.
  always_comb begin
    rem_shift_s = {rem_i[width_p-1:0], quo_i[width_p-1]};
    div_ext_s   = {1'b0, div_i};
    rem_o       = rem_shift_s;
    quo_o       = {quo_i[width_p-2:0], 1'b0};
    if (rem_shift_s >= div_ext_s) begin
      rem_o = rem_shift_s - div_ext_s;
      quo_o = {quo_i[width_p-2:0], 1'b1};
    end else begin
      rem_o = rem_shift_s;
      quo_o = {quo_i[width_p-2:0], 1'b0};
    end
  end

endmodule : divider_step

// File: rtl/shift_sub_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with
// valid/ready handshakes on both sides.
// Optional build macro SHIFT_SUB_DIVIDER_DBZ_FLAG_EN adds a divide-by-zero
// flag output (dbz_o) captured when the operands are accepted.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
  ,
  output logic               dbz_o
`endif
);

  localparam int CNT_W = $clog2(width_p);
  // Count value of the final step; the counter stops here instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width_p - 1);

  state_e             state_r;
  state_e             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [width_p:0]   rem_r;
  logic [width_p-1:0] quo_r;
  logic [width_p-1:0] div_r;
  logic [width_p:0]   rem_step_s;
  logic [width_p-1:0] quo_step_s;
  logic               last_step_s;

  divider_step #(
    .width_p (width_p)
  ) u_step (
    .rem_i (rem_r),
    .quo_i (quo_r),
    .div_i (div_r),
    .rem_o (rem_step_s),
    .quo_o (quo_step_s)
  );

  // Flags the BUSY cycle that performs the final restoring step.
  always_comb begin
    last_step_s = 1'b0;
    if ((state_r == BUSY) && (cnt_r == CNT_LAST)) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
  end

  // Next-state logic: IDLE accepts, BUSY iterates width_p steps, DONE waits for the consumer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus the handshake outputs, registered from the next state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_o <= (state_s == IDLE);
      valid_o <= (state_s == DONE);
    end
  end

  // Datapath: capture operands on accept, iterate in BUSY, publish on the last step.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {(width_p+1){1'b0}};
      quo_r       <= {width_p{1'b0}};
      div_r       <= {width_p{1'b0}};
      quotient_o  <= {width_p{1'b0}};
      remainder_o <= {width_p{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            quo_r <= dividend_i;
            div_r <= divisor_i;
            rem_r <= {(width_p+1){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          if (last_step_s) begin
            cnt_r       <= cnt_r;
            quotient_o  <= quo_step_s;
            remainder_o <= rem_step_s[width_p-1:0];
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
  // Divide-by-zero flag, sampled with the operands and held through DONE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dbz_o <= 1'b0;
    end else if ((state_r == IDLE) && valid_i) begin
      dbz_o <= (divisor_i == {width_p{1'b0}});
    end
  end
`endif

endmodule : shift_sub_divider

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: a width-4 and a width-8 instance,
// directed vectors with hand-computed results, monitors compare on valid_o.
module tb_shift_sub_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         acc;
  } item_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // width 4 instance signals
  logic       rst4_n = 1'b1;
  logic       valid_i4 = 1'b0, ready_o4, valid_o4, ready_i4 = 1'b1;
  logic [3:0] dividend_i4 = 4'd0, divisor_i4 = 4'd0, quotient_o4, remainder_o4;
  // width 8 instance signals
  logic       rst8_n = 1'b1;
  logic       valid_i8 = 1'b0, ready_o8, valid_o8, ready_i8 = 1'b1;
  logic [7:0] dividend_i8 = 8'd0, divisor_i8 = 8'd0, quotient_o8, remainder_o8;
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
  logic       dbz_o4, dbz_o8;
`endif

  item_t q4[$];
  item_t q8[$];
  bit    seen4 = 1'b0;
  bit    seen8 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sub_divider #(.width_p(4)) dut4 (
    .clk_i(clk), .reset_ni(rst4_n), .valid_i(valid_i4), .ready_o(ready_o4),
    .dividend_i(dividend_i4), .divisor_i(divisor_i4), .valid_o(valid_o4),
    .ready_i(ready_i4), .quotient_o(quotient_o4), .remainder_o(remainder_o4)
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
    , .dbz_o(dbz_o4)
`endif
  );

  shift_sub_divider #(.width_p(8)) dut8 (
    .clk_i(clk), .reset_ni(rst8_n), .valid_i(valid_i8), .ready_o(ready_o8),
    .dividend_i(dividend_i8), .divisor_i(divisor_i8), .valid_o(valid_o8),
    .ready_i(ready_i8), .quotient_o(quotient_o8), .remainder_o(remainder_o8)
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
    , .dbz_o(dbz_o8)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor for the width-4 instance: compare the head of the queue while valid_o is up.
  always @(negedge clk) begin
    if (rst4_n && valid_o4) begin
      if (q4.size() == 0) begin
        fail_now("unexpected_valid4");
      end else begin
        chk("quot4", 32'(quotient_o4), 32'(q4[0].q));
        chk("rem4", 32'(remainder_o4), 32'(q4[0].r));
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
        chk("dbz4", 32'(dbz_o4), 32'(q4[0].dbz));
`endif
        if (!seen4) begin
          chk("lat4", 32'(cyc - q4[0].acc), 32'd4);
          seen4 = 1'b1;
        end
        if (ready_i4) begin
          void'(q4.pop_front());
          seen4 = 1'b0;
        end
      end
    end
  end

  // Monitor for the width-8 instance.
  always @(negedge clk) begin
    if (rst8_n && valid_o8) begin
      if (q8.size() == 0) begin
        fail_now("unexpected_valid8");
      end else begin
        chk("quot8", 32'(quotient_o8), 32'(q8[0].q));
        chk("rem8", 32'(remainder_o8), 32'(q8[0].r));
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
        chk("dbz8", 32'(dbz_o8), 32'(q8[0].dbz));
`endif
        if (!seen8) begin
          chk("lat8", 32'(cyc - q8[0].acc), 32'd8);
          seen8 = 1'b1;
        end
        if (ready_i8) begin
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  // Present one operation to the width-4 DUT; returns 1 time unit after the accepting edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic ed, input bit push);
    int    n;
    item_t it;
    n = 0;
    @(posedge clk); #1;
    while (!ready_o4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o4) fail_now("ready4_wait");
    dividend_i4 = a;
    divisor_i4  = b;
    valid_i4    = 1'b1;
    @(posedge clk); #1;
    valid_i4 = 1'b0;
    if (push) begin
      it.q = {4'd0, eq};
      it.r = {4'd0, er};
      it.dbz = ed;
      it.acc = cyc;
      q4.push_back(it);
    end
  endtask

  // Wait until the width-4 result has been consumed, then check the block is idle again.
  task automatic wait_done4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      fail_now("done4_wait");
      q4.delete();
      seen4 = 1'b0;
    end
    @(posedge clk); #1;
    chk("idle_valid4", 32'(valid_o4), 32'd0);
    chk("idle_ready4", 32'(ready_o4), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    int    acc1;
    int    acc2;
    item_t it;

    // reset state, observed with no clock edge needed
    #1;
    rst4_n = 1'b0;
    rst8_n = 1'b0;
    #2;
    chk("rst_ready4", 32'(ready_o4), 32'd1);
    chk("rst_valid4", 32'(valid_o4), 32'd0);
    chk("rst_quot4", 32'(quotient_o4), 32'd0);
    chk("rst_rem4", 32'(remainder_o4), 32'd0);
    chk("rst_ready8", 32'(ready_o8), 32'd1);
`ifdef SHIFT_SUB_DIVIDER_DBZ_FLAG_EN
    chk("rst_dbz4", 32'(dbz_o4), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst4_n = 1'b1;
    rst8_n = 1'b1;

    // basic op, one-cycle valid and result retained in IDLE
    issue4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_done4();
    chk("keep_quot4", 32'(quotient_o4), 32'd4);
    chk("keep_rem4", 32'(remainder_o4), 32'd1);

    issue4(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 1'b1); wait_done4();
    issue4(4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 1'b1); wait_done4();
    issue4(4'd5,  4'd7,  4'd0,  4'd5, 1'b0, 1'b1); wait_done4();
    issue4(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 1'b1); wait_done4();
    // divide by zero, then an ordinary op clears the flag
    issue4(4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 1'b1); wait_done4();
    issue4(4'd6,  4'd2,  4'd3,  4'd0, 1'b0, 1'b1); wait_done4();

    // backpressure with new operands toggling during BUSY and DONE
    ready_i4 = 1'b0;
    issue4(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b1);
    n = 0;
    while (!valid_o4 && n < 20) begin
      valid_i4    = ~valid_i4;
      dividend_i4 = 4'(n);
      divisor_i4  = 4'd1;
      @(posedge clk); #1;
      n++;
    end
    if (!valid_o4) fail_now("bp_valid4");
    for (int i = 0; i < 6; i++) begin
      valid_i4    = ~valid_i4;
      dividend_i4 = 4'(i + 3);
      divisor_i4  = 4'd3;
      @(posedge clk); #1;
    end
    valid_i4 = 1'b0;
    ready_i4 = 1'b1;
    wait_done4();

    // asynchronous reset in the middle of BUSY step 2
    issue4(4'd12, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst4_n = 1'b0;
    #1;
    chk("abort_valid4", 32'(valid_o4), 32'd0);
    chk("abort_ready4", 32'(ready_o4), 32'd1);
    chk("abort_quot4", 32'(quotient_o4), 32'd0);
    chk("abort_rem4", 32'(remainder_o4), 32'd0);
    #3;
    rst4_n = 1'b1;
    issue4(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done4();

    // width 8 back-to-back with valid_i and ready_i held high
    @(posedge clk); #1;
    n = 0;
    while (!ready_o8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    dividend_i8 = 8'd255;
    divisor_i8  = 8'd16;
    valid_i8    = 1'b1;
    ready_i8    = 1'b1;
    @(posedge clk); #1;
    acc1 = cyc;
    it.q = 8'd15; it.r = 8'd15; it.dbz = 1'b0; it.acc = acc1;
    q8.push_back(it);
    dividend_i8 = 8'd200;
    divisor_i8  = 8'd7;
    n = 0;
    while (!ready_o8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o8) fail_now("b2b_ready8");
    @(posedge clk); #1;
    acc2 = cyc;
    valid_i8 = 1'b0;
    it.q = 8'd28; it.r = 8'd4; it.dbz = 1'b0; it.acc = acc2;
    q8.push_back(it);
    chk("b2b_spacing8", 32'(acc2 - acc1), 32'd10);
    n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) fail_now("done8_wait");
    @(posedge clk); #1;
    chk("idle_ready8", 32'(ready_o8), 32'd1);
    chk("keep_quot8", 32'(quotient_o8), 32'd28);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_sub_divider
